// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle for the multi-cycle processor.
// master = control unit, slave = datapath and shared memory side.
interface multicycle_control_unit_if #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                PCWrite;
    logic                PCSrc;
    logic                ALUOp;
    logic                ALUSrc;
    logic                RegWrite;
    logic                MemToReg;
    logic                busy;
    logic                illegal;
    logic                mem_error;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUOp, ALUSrc,
               RegWrite, MemToReg, busy, illegal, mem_error, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUOp, ALUSrc,
               RegWrite, MemToReg, busy, illegal, mem_error, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with bounded memory handshake.
// Define CU_BRANCH_EN to decode opcode 011 as beq; otherwise 011 is illegal.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(3'b001);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(3'b100);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(3'b010);
`ifdef CU_BRANCH_EN
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(3'b011);
`endif

    typedef enum logic [2:0] {StReset, StFetch, StDecode, StExec, StMem, StWb} state_e;

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q;
    logic                retire, timeout, legal, mem_access;
    logic                op_lw, op_sw, op_add;

    assign op_lw  = (op_q == OP_LW);
    assign op_sw  = (op_q == OP_SW);
    assign op_add = (op_q == OP_ADD);

`ifdef CU_BRANCH_EN
    assign legal = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) || (bus.opcode == OP_ADD) ||
                   (bus.opcode == OP_BEQ);
`else
    assign legal = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) || (bus.opcode == OP_ADD);
`endif

    // Derived from state, not from mem_req, to keep the timeout path loop-free.
    assign mem_access = (state_q == StFetch) || (state_q == StMem);
    assign timeout    = mem_access && !bus.mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign wait_d     = (mem_access && !bus.mem_ready && !timeout) ? wait_q + WAIT_W'(1)
                                                                    : '0;
    assign bus.busy    = (state_q != StReset);
    assign bus.retired = retired_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        retire        = 1'b0;
        bus.mem_req   = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.PCSrc     = 1'b0;
        bus.ALUOp     = 1'b0;
        bus.ALUSrc    = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemToReg  = 1'b0;
        bus.illegal   = 1'b0;
        bus.mem_error = 1'b0;
        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                bus.mem_req = 1'b1;
                bus.MemRead = 1'b1;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = StDecode;
                end else if (timeout) begin
                    bus.mem_error = 1'b1;
                    state_d       = StFetch;
                end
            end
            StDecode: begin
                op_d = bus.opcode;
                if (legal) begin
                    state_d = StExec;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = StFetch;
                end
            end
            StExec: begin
                bus.ALUOp  = 1'b1;
                bus.ALUSrc = op_lw || op_sw;
                if (op_lw || op_sw) begin
                    state_d = StMem;
                end else if (op_add) begin
                    state_d = StWb;
                end else begin
`ifdef CU_BRANCH_EN
                    if (op_q == OP_BEQ) begin
                        bus.PCWrite = bus.zero;
                        bus.PCSrc   = 1'b1;
                        retire      = 1'b1;
                    end
`endif
                    state_d = StFetch;
                end
            end
            StMem: begin
                bus.mem_req  = 1'b1;
                bus.IorD     = 1'b1;
                bus.MemRead  = op_lw;
                bus.MemWrite = op_sw;
                if (bus.mem_ready) begin
                    if (op_lw) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else if (timeout) begin
                    // Abandon the access; the instruction does not retire.
                    bus.mem_error = 1'b1;
                    state_d       = StFetch;
                end
            end
            StWb: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = op_lw;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StReset;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end
endmodule
